// File: rtl/rtc_core.sv
// Real-time clock core: prescaled seconds tick, up/down time counting with
// validated loads, alarm compare and a packed BCD view of the current time.
module rtc_core #(
    parameter int TICK_DIV = 50_000_000,
    parameter int HOURS    = 24
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        dir,
    input  logic        load,
    input  logic [5:0]  load_hour,
    input  logic [5:0]  load_min,
    input  logic [5:0]  load_sec,
    input  logic [5:0]  alarm_hour,
    input  logic [5:0]  alarm_min,
    input  logic [5:0]  alarm_sec,
    input  logic        alarm_arm,
    output logic [5:0]  hour,
    output logic [5:0]  min,
    output logic [5:0]  second,
    output logic [31:0] time_data,
    output logic        sec_pulse,
    output logic        day_wrap,
    output logic        done,
    output logic        alarm_hit,
    output logic        load_err
);

    localparam int             PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  PRE_MAX  = PW'(TICK_DIV - 1);
    localparam logic [5:0]     HOUR_MAX = 6'(HOURS - 1);

    logic [PW-1:0] pre_q, pre_d;
    logic [5:0]    hour_q, hour_d, min_q, min_d, sec_q, sec_d;
    logic          sec_pulse_q, sec_pulse_d, day_wrap_q, day_wrap_d;
    logic          done_q, done_d, alarm_hit_q, alarm_hit_d, load_err_q, load_err_d;

    logic          tick, load_ok, at_zero, adv;
    logic          carry_s, carry_m, bor_s, bor_m;
    logic [5:0]    up_h, up_m, up_s, dn_h, dn_m, dn_s;

    // Two-digit BCD for values 0..59, built from a tens-digit compare chain.
    function automatic logic [7:0] bcd(input logic [5:0] v);
        logic [3:0] t;
        logic [5:0] rem;
        if      (v >= 6'd50) t = 4'd5;
        else if (v >= 6'd40) t = 4'd4;
        else if (v >= 6'd30) t = 4'd3;
        else if (v >= 6'd20) t = 4'd2;
        else if (v >= 6'd10) t = 4'd1;
        else                 t = 4'd0;
        rem = v - (6'(t) * 6'd10);
        return {t, 4'(rem)};
    endfunction

    // Wrap compares happen before any increment/decrement, so nothing exceeds 59.
    always_comb begin
        tick    = run && (pre_q == PRE_MAX);
        load_ok = (load_sec < 6'd60) && (load_min < 6'd60) && (load_hour <= HOUR_MAX);
        at_zero = (hour_q == 6'd0) && (min_q == 6'd0) && (sec_q == 6'd0);

        carry_s = (sec_q == 6'd59);
        carry_m = carry_s && (min_q == 6'd59);
        up_s    = carry_s ? 6'd0 : sec_q + 6'd1;
        up_m    = carry_s ? ((min_q == 6'd59) ? 6'd0 : min_q + 6'd1) : min_q;
        up_h    = carry_m ? ((hour_q == HOUR_MAX) ? 6'd0 : hour_q + 6'd1) : hour_q;

        bor_s   = (sec_q == 6'd0);
        bor_m   = bor_s && (min_q == 6'd0);
        dn_s    = bor_s ? 6'd59 : sec_q - 6'd1;
        dn_m    = bor_s ? ((min_q == 6'd0) ? 6'd59 : min_q - 6'd1) : min_q;
        dn_h    = bor_m ? hour_q - 6'd1 : hour_q;
    end

    always_comb begin
        pre_d       = pre_q;
        hour_d      = hour_q;
        min_d       = min_q;
        sec_d       = sec_q;
        sec_pulse_d = 1'b0;
        day_wrap_d  = 1'b0;
        done_d      = 1'b0;
        load_err_d  = 1'b0;
        adv         = 1'b0;

        if (load) begin
            if (load_ok) begin
                hour_d = load_hour;
                min_d  = load_min;
                sec_d  = load_sec;
                pre_d  = '0;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (run) begin
            pre_d = tick ? '0 : pre_q + PW'(1);
            if (tick && !dir) begin
                hour_d      = up_h;
                min_d       = up_m;
                sec_d       = up_s;
                adv         = 1'b1;
                sec_pulse_d = 1'b1;
                day_wrap_d  = (up_h == 6'd0) && (up_m == 6'd0) && (up_s == 6'd0);
            end else if (tick && !at_zero) begin
                // A countdown parked at 00:00:00 stays silent on later ticks.
                hour_d      = dn_h;
                min_d       = dn_m;
                sec_d       = dn_s;
                adv         = 1'b1;
                sec_pulse_d = 1'b1;
                done_d      = (dn_h == 6'd0) && (dn_m == 6'd0) && (dn_s == 6'd0);
            end
        end

        alarm_hit_d = adv && alarm_arm && (hour_d == alarm_hour) &&
                      (min_d == alarm_min) && (sec_d == alarm_sec);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q       <= '0;
            hour_q      <= 6'd0;
            min_q       <= 6'd0;
            sec_q       <= 6'd0;
            sec_pulse_q <= 1'b0;
            day_wrap_q  <= 1'b0;
            done_q      <= 1'b0;
            alarm_hit_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            pre_q       <= pre_d;
            hour_q      <= hour_d;
            min_q       <= min_d;
            sec_q       <= sec_d;
            sec_pulse_q <= sec_pulse_d;
            day_wrap_q  <= day_wrap_d;
            done_q      <= done_d;
            alarm_hit_q <= alarm_hit_d;
            load_err_q  <= load_err_d;
        end
    end

    assign hour      = hour_q;
    assign min       = min_q;
    assign second    = sec_q;
    assign sec_pulse = sec_pulse_q;
    assign day_wrap  = day_wrap_q;
    assign done      = done_q;
    assign alarm_hit = alarm_hit_q;
    assign load_err  = load_err_q;
    assign time_data = {8'h00, bcd(hour_q), bcd(min_q), bcd(sec_q)};

endmodule

// File: tb/tb_rtc_core.sv
// Directed bench for rtc_core (TICK_DIV=4, HOURS=24): stimulus pushes expected
// pulse events into a scoreboard; a negedge monitor pops one per observed pulse.
module tb_rtc_core;

    logic        clk = 1'b0;
    logic        reset, run, dir, load, alarm_arm;
    logic [5:0]  load_hour, load_min, load_sec;
    logic [5:0]  alarm_hour, alarm_min, alarm_sec;
    logic [5:0]  hour, min, second;
    logic [31:0] time_data;
    logic        sec_pulse, day_wrap, done, alarm_hit, load_err;

    always #5 clk = ~clk;

    rtc_core #(.TICK_DIV(4), .HOURS(24)) dut (
        .clk(clk), .reset(reset), .run(run), .dir(dir), .load(load),
        .load_hour(load_hour), .load_min(load_min), .load_sec(load_sec),
        .alarm_hour(alarm_hour), .alarm_min(alarm_min), .alarm_sec(alarm_sec),
        .alarm_arm(alarm_arm),
        .hour(hour), .min(min), .second(second), .time_data(time_data),
        .sec_pulse(sec_pulse), .day_wrap(day_wrap), .done(done),
        .alarm_hit(alarm_hit), .load_err(load_err)
    );

    // Pulse flag order: {sec_pulse, day_wrap, done, alarm_hit, load_err}
    localparam logic [4:0] SP = 5'b10000, DW = 5'b01000, DN = 5'b00100,
                           AH = 5'b00010, LE = 5'b00001;

    typedef struct {
        logic [5:0] h, m, s;
        logic [4:0] flags;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    always @(negedge clk) begin
        if (sec_pulse | day_wrap | done | alarm_hit | load_err) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got flags %b at %0d:%0d:%0d expected none",
                         {sec_pulse, day_wrap, done, alarm_hit, load_err}, hour, min, second);
            end else begin
                mon_e = sb.pop_front();
                chk("pulse_flags", 32'({sec_pulse, day_wrap, done, alarm_hit, load_err}),
                    32'(mon_e.flags));
                chk("pulse_time", 32'({hour, min, second}), 32'({mon_e.h, mon_e.m, mon_e.s}));
                chk("pulse_bcd", time_data,
                    {8'h00, to_bcd(int'(mon_e.h)), to_bcd(int'(mon_e.m)), to_bcd(int'(mon_e.s))});
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int h, input int m, input int s, input logic [4:0] f);
        exp_t e;
        e.h = 6'(h); e.m = 6'(m); e.s = 6'(s); e.flags = f;
        sb.push_back(e);
    endtask

    task automatic do_load(input int h, input int m, input int s);
        load_hour = 6'(h); load_min = 6'(m); load_sec = 6'(s);
        load = 1'b1;
        cyc(1);
        load = 1'b0;
    endtask

    // Let the monitor see the most recent edge before checking the queue.
    task automatic drained(input string name);
        @(negedge clk);
        #1;
        chk(name, 32'(sb.size()), 32'd0);
    endtask

    task automatic chk_time(input string name, input int h, input int m, input int s);
        chk(name, 32'({hour, min, second}), 32'({6'(h), 6'(m), 6'(s)}));
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; dir = 1'b0; load = 1'b0; alarm_arm = 1'b0;
        load_hour = '0; load_min = '0; load_sec = '0;
        alarm_hour = '0; alarm_min = '0; alarm_sec = '0;
        cyc(2);
        reset = 1'b0;
        chk_time("reset_time", 0, 0, 0);
        chk("reset_bcd", time_data, 32'h0000_0000);
        chk("reset_pulses", 32'({sec_pulse, day_wrap, done, alarm_hit, load_err}), 32'd0);

        // 12 cycles of up-count: one tick per 4 cycles
        push(0, 0, 1, SP); push(0, 0, 2, SP); push(0, 0, 3, SP);
        run = 1'b1; cyc(12); run = 1'b0;
        drained("upcount_pulses");
        chk_time("upcount_time", 0, 0, 3);

        // Day rollover
        do_load(23, 59, 59);
        chk("load_bcd", time_data, 32'h0023_5959);
        push(0, 0, 0, SP | DW);
        run = 1'b1; cyc(4); run = 1'b0;
        drained("daywrap_pulse");
        chk("daywrap_bcd", time_data, 32'h0000_0000);

        // Countdown with minute borrow, reaching zero, then holding
        dir = 1'b1;
        do_load(0, 1, 0);
        push(0, 0, 59, SP); push(0, 0, 58, SP);
        run = 1'b1; cyc(8); run = 1'b0;
        drained("down_borrow");
        chk_time("down_time", 0, 0, 58);
        do_load(0, 0, 1);
        push(0, 0, 0, SP | DN);
        run = 1'b1; cyc(4);
        drained("down_done");
        cyc(12); run = 1'b0;
        drained("down_hold_silent");
        chk_time("down_hold_time", 0, 0, 0);

        // Invalid load, then valid load colliding with a tick
        dir = 1'b0;
        push(0, 0, 0, LE);
        do_load(12, 60, 0);
        drained("bad_load_err");
        chk_time("bad_load_time", 0, 0, 0);
        run = 1'b1; cyc(3);
        do_load(10, 59, 58);
        run = 1'b0;
        drained("load_beats_tick");
        chk_time("load_tick_time", 10, 59, 58);
        run = 1'b1; cyc(3);
        chk_time("pre_cleared", 10, 59, 58);
        push(10, 59, 59, SP);
        cyc(1); run = 1'b0;
        drained("after_load_tick");

        // Alarm: hit on tick advance, never on load, not when disarmed
        alarm_hour = 6'd1; alarm_min = 6'd0; alarm_sec = 6'd0; alarm_arm = 1'b1;
        do_load(0, 59, 59);
        push(1, 0, 0, SP | AH);
        run = 1'b1; cyc(4); run = 1'b0;
        drained("alarm_hit");
        do_load(1, 0, 0);
        drained("load_no_alarm");
        chk_time("load_alarm_time", 1, 0, 0);
        alarm_arm = 1'b0;
        do_load(0, 59, 59);
        push(1, 0, 0, SP);
        run = 1'b1; cyc(4); run = 1'b0;
        drained("alarm_disarmed");

        // Direction flip mid-prescale keeps time and prescaler
        run = 1'b1; cyc(2);
        dir = 1'b1;
        push(0, 59, 59, SP);
        cyc(2); run = 1'b0;
        drained("dir_change");

        // Reset mid-count and mid-load
        dir = 1'b0;
        run = 1'b1; cyc(2);
        reset = 1'b1;
        load_hour = 6'd5; load_min = 6'd5; load_sec = 6'd5; load = 1'b1;
        cyc(1);
        reset = 1'b0; load = 1'b0;
        chk_time("midreset_time", 0, 0, 0);
        chk("midreset_bcd", time_data, 32'h0000_0000);
        chk("midreset_pulses", 32'({sec_pulse, day_wrap, done, alarm_hit, load_err}), 32'd0);
        cyc(3);
        chk_time("midreset_no_early", 0, 0, 0);
        push(0, 0, 1, SP);
        cyc(1); run = 1'b0;
        drained("midreset_first_tick");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
